// File: rtl/nrs_pkg.sv
// Shared constants, FSM state type and c_init helper for the NB-IoT NRS generator.
package nrs_pkg;

  localparam int NC            = 1600;
  localparam int M_PRIME_FIRST = 109;
  localparam int NID_MAX       = 503;
  localparam int NS_MAX        = 19;
  localparam int L_MAX         = 6;
  localparam int WARM_STEPS    = NC + 2 * M_PRIME_FIRST;

  localparam logic signed [15:0] NRS_POS = 16'sh05A8;
  localparam logic signed [15:0] NRS_NEG = 16'shFA58;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WARM,
    ST_EMIT
  } nrs_state_e;

  // c_init = 2^10 * (7*(ns+1)+l+1) * (2*nid+1) + 2*nid + 1, fits in 31 bits for legal inputs
  function automatic logic [30:0] calc_c_init(input logic [8:0] nid,
                                              input logic [4:0] ns,
                                              input logic [2:0] l);
    logic [30:0] sym;
    logic [30:0] cid;
    sym = 31'd7 * ({26'd0, ns} + 31'd1) + {28'd0, l} + 31'd1;
    cid = {21'd0, nid, 1'b1};
    return ((sym * cid) << 10) + cid;
  endfunction

endpackage

// File: rtl/gold_seq_gen.sv
// Length-31 Gold sequence generator: two LFSRs and the output XOR, one step per adv.
module gold_seq_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        adv,
  input  logic [30:0] c_init,
  output logic        c_bit
);

  // bit i of each register holds x(n+i); the new bit enters at the top
  logic [30:0] x1;
  logic [30:0] x2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x1 <= 31'd0;
      x2 <= 31'd0;
    end else if (load) begin
      x1 <= 31'h1;
      x2 <= c_init;
    end else if (adv) begin
      x1 <= {x1[3] ^ x1[0], x1[30:1]};
      x2 <= {x2[3] ^ x2[2] ^ x2[1] ^ x2[0], x2[30:1]};
    end
  end

  assign c_bit = x1[0] ^ x2[0];

endmodule

// File: rtl/nrs_seq_gen.sv
// NB-IoT NRS pair generator: warms the Gold sequence to c(218), then emits pairs m'=109 and 110.
module nrs_seq_gen
  import nrs_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [8:0]         n_cell_id,
  input  logic [4:0]         ns,
  input  logic [2:0]         l,
  output logic               nrs_r,
  output logic               nrs_i,
  output logic signed [15:0] nrs_r_val,
  output logic signed [15:0] nrs_i_val,
  output logic               nrs_valid,
  output logic               busy,
  output logic               done,
  output logic               err,
  output nrs_state_e         state_dbg
);

  // Handshake: start is a one-cycle request sampled only in IDLE; nrs_valid is a
  // one-cycle qualifier for nrs_r/nrs_i/nrs_*_val with no backpressure.

  localparam logic [10:0] WARM_LAST = 11'(WARM_STEPS - 1);

  nrs_state_e  state, next_state;
  logic [10:0] cnt;
  logic [8:0]  nid_q;
  logic [4:0]  ns_q;
  logic [2:0]  l_q;
  logic        load, adv, legal, accept;
  logic [30:0] c_init;
  logic        c_bit;
  logic        even_bit;
  logic [1:0]  pair_q;
  logic        pair_rdy, pair_last;

  assign legal  = (n_cell_id <= 9'(NID_MAX)) && (ns <= 5'(NS_MAX)) && (l <= 3'(L_MAX));
  assign accept = (state == ST_IDLE) && start && legal;
  assign c_init = calc_c_init(nid_q, ns_q, l_q);
  assign state_dbg = state;

  gold_seq_gen u_gold (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .adv    (adv),
    .c_init (c_init),
    .c_bit  (c_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    adv        = 1'b0;
    case (state)
      ST_IDLE: if (accept) next_state = ST_LOAD;
      ST_LOAD: begin
        load       = 1'b1;
        next_state = ST_WARM;
      end
      ST_WARM: begin
        adv = 1'b1;
        if (cnt == WARM_LAST) next_state = ST_EMIT;
      end
      ST_EMIT: begin
        adv = 1'b1;
        if (cnt == 11'd3) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Control, step counter and the even/odd pair capture during EMIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 11'd0;
      nid_q     <= 9'd0;
      ns_q      <= 5'd0;
      l_q       <= 3'd0;
      busy      <= 1'b0;
      err       <= 1'b0;
      even_bit  <= 1'b0;
      pair_q    <= 2'b00;
      pair_rdy  <= 1'b0;
      pair_last <= 1'b0;
    end else begin
      err  <= (state == ST_IDLE) && start && !legal;
      busy <= (next_state != ST_IDLE);
      if (accept) begin
        nid_q <= n_cell_id;
        ns_q  <= ns;
        l_q   <= l;
      end
      case (state)
        ST_WARM: cnt <= (cnt == WARM_LAST) ? 11'd0 : cnt + 11'd1;
        ST_EMIT: cnt <= cnt + 11'd1;
        default: cnt <= 11'd0;
      endcase
      pair_rdy <= 1'b0;
      if (state == ST_EMIT) begin
        if (!cnt[0]) begin
          even_bit <= c_bit;
        end else begin
          pair_q    <= {even_bit, c_bit};
          pair_rdy  <= 1'b1;
          pair_last <= cnt[1];
        end
      end
    end
  end

  // Output register stage: values held between valid pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nrs_valid <= 1'b0;
      done      <= 1'b0;
      nrs_r     <= 1'b0;
      nrs_i     <= 1'b0;
      nrs_r_val <= 16'sh0000;
      nrs_i_val <= 16'sh0000;
    end else begin
      nrs_valid <= pair_rdy;
      done      <= pair_rdy && pair_last;
      if (pair_rdy) begin
        nrs_r     <= pair_q[1];
        nrs_i     <= pair_q[0];
        nrs_r_val <= pair_q[1] ? NRS_NEG : NRS_POS;
        nrs_i_val <= pair_q[0] ? NRS_NEG : NRS_POS;
      end
    end
  end

endmodule
